// File: rtl/lap_timer_if.sv
// lap_timer_if: control, load and lap-buffer signals of the lap timer.
// Latency: n/a (signal bundle only).
// Backpressure: none; lap_rd pops the buffer head, lap_valid marks head valid.
// master: drives run/clear/count_down/load/load_epoch/load_m/lap/lap_rd,
//         observes the count, lap buffer and sticky flags.
// slave : the timer; the mirror image of master.
interface lap_timer_if;
  logic        run;
  logic        clear;
  logic        count_down;
  logic        load;
  logic [17:0] load_epoch;
  logic [6:0]  load_m;
  logic        lap;
  logic        lap_rd;
  logic [17:0] epoch;
  logic [7:0]  m_epoch;
  logic [24:0] lap_epoch;
  logic        lap_valid;
  logic [4:0]  lap_count;
  logic        lap_lost;
  logic        expired;
  logic        overflow;

  modport master (
    output run, clear, count_down, load, load_epoch, load_m, lap, lap_rd,
    input  epoch, m_epoch, lap_epoch, lap_valid, lap_count, lap_lost,
           expired, overflow
  );

  modport slave (
    input  run, clear, count_down, load, load_epoch, load_m, lap, lap_rd,
    output epoch, m_epoch, lap_epoch, lap_valid, lap_count, lap_lost,
           expired, overflow
  );
endinterface

// File: rtl/lap_timer.sv
// lap_timer: hh:mm:ss.cc up/down counter with lap capture buffer.
// Latency: count updates one cycle after a tick; a lap appears at the buffer head the cycle after capture.
// Backpressure: none; a lap arriving at a full buffer (without a pop) is dropped and lap_lost is set.
// Ports: clock, reset_n (async active-low); bus (lap_timer_if.slave):
//   run/clear/count_down/load/load_epoch/load_m/lap/lap_rd in,
//   epoch/m_epoch/lap_epoch/lap_valid/lap_count/lap_lost/expired/overflow out.
// Optional feature: define LAP_TIMER_LAP_BUFFER_EN to build the lap buffer;
// otherwise lap/lap_rd are ignored and the lap outputs are tied to 0.
module lap_timer #(
  parameter int CLOCK_HZ  = 50000000,
  parameter int TICK_HZ   = 100,
  parameter int LAP_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  lap_timer_if.slave  bus
);

  localparam int            DIV      = CLOCK_HZ / TICK_HZ;
  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] divider;
  logic [4:0]    hour;
  logic [5:0]    minute;
  logic [5:0]    second;
  logic [6:0]    cs;
  logic          expired_q;
  logic          overflow_q;

  logic          tick;
  logic          is_zero;
  logic          is_one;
  logic [4:0]    nxt_hour;
  logic [5:0]    nxt_minute;
  logic [5:0]    nxt_second;
  logic [6:0]    nxt_cs;
  logic          set_ovf;
  logic          set_exp;
  logic [4:0]    ld_hour;
  logic [5:0]    ld_minute;
  logic [5:0]    ld_second;
  logic [6:0]    ld_cs;

  assign tick    = bus.run && (divider == DIV_LAST);
  assign is_zero = (hour == 5'd0) && (minute == 6'd0) && (second == 6'd0) && (cs == 7'd0);
  assign is_one  = (hour == 5'd0) && (minute == 6'd0) && (second == 6'd0) && (cs == 7'd1);

  // Out-of-range load fields clamp to the field maximum.
  assign ld_hour   = (bus.load_epoch[17:12] > 6'd23) ? 5'd23 : bus.load_epoch[16:12];
  assign ld_minute = (bus.load_epoch[11:6]  > 6'd59) ? 6'd59 : bus.load_epoch[11:6];
  assign ld_second = (bus.load_epoch[5:0]   > 6'd59) ? 6'd59 : bus.load_epoch[5:0];
  assign ld_cs     = (bus.load_m > 7'd99) ? 7'd99 : bus.load_m;

  // Count value after one tick; the whole carry/borrow chain resolves in one step.
  always_comb begin
    nxt_hour   = hour;
    nxt_minute = minute;
    nxt_second = second;
    nxt_cs     = cs;
    set_ovf    = 1'b0;
    set_exp    = 1'b0;
    if (!bus.count_down) begin
      if (cs == 7'd99) begin
        nxt_cs = 7'd0;
        if (second == 6'd59) begin
          nxt_second = 6'd0;
          if (minute == 6'd59) begin
            nxt_minute = 6'd0;
            if (hour == 5'd23) begin
              nxt_hour = 5'd0;
              set_ovf  = 1'b1;
            end else begin
              nxt_hour = hour + 5'd1;
            end
          end else begin
            nxt_minute = minute + 6'd1;
          end
        end else begin
          nxt_second = second + 6'd1;
        end
      end else begin
        nxt_cs = cs + 7'd1;
      end
    end else if (!is_zero) begin
      // A non-zero count never borrows out of the hour field.
      set_exp = is_one;
      if (cs == 7'd0) begin
        nxt_cs = 7'd99;
        if (second == 6'd0) begin
          nxt_second = 6'd59;
          if (minute == 6'd0) begin
            nxt_minute = 6'd59;
            nxt_hour   = hour - 5'd1;
          end else begin
            nxt_minute = minute - 6'd1;
          end
        end else begin
          nxt_second = second - 6'd1;
        end
      end else begin
        nxt_cs = cs - 7'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      divider    <= '0;
      hour       <= '0;
      minute     <= '0;
      second     <= '0;
      cs         <= '0;
      expired_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      divider    <= '0;
      hour       <= '0;
      minute     <= '0;
      second     <= '0;
      cs         <= '0;
      expired_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.load) begin
      divider    <= '0;
      hour       <= ld_hour;
      minute     <= ld_minute;
      second     <= ld_second;
      cs         <= ld_cs;
      expired_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else if (bus.run) begin
      divider <= tick ? '0 : divider + DW'(1);
      if (tick) begin
        hour   <= nxt_hour;
        minute <= nxt_minute;
        second <= nxt_second;
        cs     <= nxt_cs;
        if (set_ovf) overflow_q <= 1'b1;
        if (set_exp) expired_q  <= 1'b1;
      end
    end
  end

  assign bus.epoch    = {1'b0, hour, minute, second};
  assign bus.m_epoch  = {1'b0, cs};
  assign bus.expired  = expired_q;
  assign bus.overflow = overflow_q;

`ifdef LAP_TIMER_LAP_BUFFER_EN
  localparam int AW = $clog2(LAP_DEPTH);

  logic [24:0]   lap_mem [LAP_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    lap_cnt;
  logic          lost_q;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic [24:0]   snapshot;

  assign full     = (lap_cnt == 5'(LAP_DEPTH));
  assign empty    = (lap_cnt == 5'd0);
  assign do_pop   = bus.lap_rd && !empty;
  // A simultaneous pop frees the slot, so a full buffer still accepts the lap.
  assign do_push  = bus.lap && (!full || do_pop);
  // Registered count is the value before this cycle's tick/load takes effect.
  assign snapshot = {1'b0, hour, minute, second, cs};

  always_ff @(posedge clock) begin
    if (do_push) lap_mem[wr_ptr] <= snapshot;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lap_cnt <= '0;
      lost_q  <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lap_cnt <= '0;
      lost_q  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   lap_cnt <= lap_cnt + 5'd1;
        2'b01:   lap_cnt <= lap_cnt - 5'd1;
        default: lap_cnt <= lap_cnt;
      endcase
      if (bus.lap && full && !bus.lap_rd) lost_q <= 1'b1;
    end
  end

  // Head is masked while empty so stale storage never shows after reset/clear.
  assign bus.lap_epoch = empty ? 25'd0 : lap_mem[rd_ptr];
  assign bus.lap_valid = !empty;
  assign bus.lap_count = lap_cnt;
  assign bus.lap_lost  = lost_q;
`else
  logic unused_lap_inputs;
  assign unused_lap_inputs = ^{bus.lap, bus.lap_rd, 5'(LAP_DEPTH)};

  assign bus.lap_epoch = 25'd0;
  assign bus.lap_valid = 1'b0;
  assign bus.lap_count = 5'd0;
  assign bus.lap_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_lap_timer.sv
// tb_lap_timer: directed scoreboard bench for lap_timer (DIV = 100/10 = 10).
// Latency: checks sample on the falling edge after each stimulus step.
// Backpressure: none; lap reads compare the head whenever lap_rd meets lap_valid.
module tb_lap_timer;

`ifdef LAP_TIMER_LAP_BUFFER_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [17:0] epoch;
    logic [7:0]  m;
    logic        expired;
    logic        overflow;
    logic        lost;
    logic [4:0]  cnt;
    logic        valid;
    logic        chk_lape;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;

  lap_timer_if bus ();

  lap_timer #(
    .CLOCK_HZ (100),
    .TICK_HZ  (10),
    .LAP_DEPTH(4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  exp_t        exp_q[$];
  logic [24:0] lap_q[$];
  logic        chk_req = 1'b0;
  logic        fin_req = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          range_bad = 0;
  exp_t        e;
  logic [24:0] le;

  // Monitor: pops expectations whenever a check is requested or a lap is read.
  always @(negedge clock) begin
    if (chk_req) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL check_queue: got a check request, required a queued expectation");
      end else begin
        e = exp_q.pop_front();
        if (bus.epoch !== e.epoch || bus.m_epoch !== e.m || bus.expired !== e.expired ||
            bus.overflow !== e.overflow || bus.lap_lost !== e.lost || bus.lap_count !== e.cnt ||
            bus.lap_valid !== e.valid || (e.chk_lape && bus.lap_epoch !== 25'd0)) begin
          fails++;
          $display("FAIL %s: got epoch=%h m=%0d exp=%b ovf=%b lost=%b cnt=%0d vld=%b lape=%h; required epoch=%h m=%0d exp=%b ovf=%b lost=%b cnt=%0d vld=%b%s",
                   e.name, bus.epoch, bus.m_epoch, bus.expired, bus.overflow, bus.lap_lost,
                   bus.lap_count, bus.lap_valid, bus.lap_epoch, e.epoch, e.m, e.expired,
                   e.overflow, e.lost, e.cnt, e.valid, e.chk_lape ? " lape=0" : "");
        end
      end
    end
    if (bus.lap_rd && bus.lap_valid) begin
      tests++;
      if (lap_q.size() == 0) begin
        fails++;
        $display("FAIL lap_read: got unexpected entry %h, required no valid entry", bus.lap_epoch);
      end else begin
        le = lap_q.pop_front();
        if (bus.lap_epoch !== le) begin
          fails++;
          $display("FAIL lap_read: got %h, required %h", bus.lap_epoch, le);
        end
      end
    end
    if (reset_n && (bus.m_epoch > 8'd99 || bus.epoch[5:0] > 6'd59 ||
                    bus.epoch[11:6] > 6'd59 || bus.epoch[17:12] > 6'd23))
      range_bad++;
    if (fin_req) begin
      tests += 3;
      if (lap_q.size() != 0) begin
        fails++;
        $display("FAIL laps_drained: got %0d unread, required 0", lap_q.size());
      end
      if (exp_q.size() != 0) begin
        fails++;
        $display("FAIL checks_drained: got %0d pending, required 0", exp_q.size());
      end
      if (range_bad != 0) begin
        fails++;
        $display("FAIL field_range: got %0d out-of-range cycles, required 0", range_bad);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] h, input logic [5:0] mi,
                       input logic [5:0] s, input logic [6:0] m, input logic ex,
                       input logic ov, input logic lost, input logic [4:0] cnt,
                       input logic all0);
    exp_t x;
    x.name     = name;
    x.epoch    = {h, mi, s};
    x.m        = {1'b0, m};
    x.expired  = ex;
    x.overflow = ov;
    x.lost     = BUF_EN ? lost : 1'b0;
    x.cnt      = BUF_EN ? cnt : 5'd0;
    x.valid    = (x.cnt != 5'd0);
    x.chk_lape = all0 || !BUF_EN;
    exp_q.push_back(x);
    chk_req = 1'b1;
    step();
    chk_req = 1'b0;
  endtask

  task automatic exp_lap(input logic [5:0] h, input logic [5:0] mi,
                         input logic [5:0] s, input logic [6:0] m);
    if (BUF_EN) lap_q.push_back({h, mi, s, m});
  endtask

  task automatic do_load(input logic [5:0] h, input logic [5:0] mi,
                         input logic [5:0] s, input logic [6:0] m);
    bus.load_epoch = {h, mi, s};
    bus.load_m     = m;
    bus.load       = 1'b1;
    step();
    bus.load       = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    bus.run = 1'b1;
    repeat (n) step();
    bus.run = 1'b0;
  endtask

  task automatic lap_pulse();
    bus.lap = 1'b1;
    step();
    bus.lap = 1'b0;
  endtask

  task automatic rd_pulse();
    bus.lap_rd = 1'b1;
    step();
    bus.lap_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required the run to finish first");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n        = 1'b0;
    bus.run        = 1'b0;
    bus.clear      = 1'b0;
    bus.count_down = 1'b0;
    bus.load       = 1'b0;
    bus.load_epoch = '0;
    bus.load_m     = '0;
    bus.lap        = 1'b0;
    bus.lap_rd     = 1'b0;
    repeat (3) step();
    check("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_n = 1'b1;
    step();
    check("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Divider: first tick on the 10th run cycle; 1000 cycles make 100 ticks.
    run_cycles(9);
    check("div_9_no_tick", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycles(1);
    check("first_tick", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_cycles(990);
    check("100_ticks", 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Up-count wrap and load saturation (load also clears overflow).
    do_load(23, 59, 59, 99);
    check("load_max", 23, 59, 59, 99, 0, 0, 0, 0, 0);
    run_cycles(10);
    check("overflow_wrap", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    do_load(63, 60, 61, 127);
    check("load_saturate", 23, 59, 59, 99, 0, 0, 0, 0, 0);

    // Down-count to zero, then hold.
    bus.count_down = 1'b1;
    do_load(0, 0, 0, 2);
    run_cycles(10);
    check("down_to_1", 0, 0, 0, 1, 0, 0, 0, 0, 0);
    run_cycles(10);
    check("down_to_0", 0, 0, 0, 0, 1, 0, 0, 0, 0);
    run_cycles(10);
    check("down_hold_0", 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Full borrow chain, then mode switch and full carry chain.
    do_load(1, 0, 0, 0);
    check("load_clr_expired", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycles(10);
    check("borrow_chain", 0, 59, 59, 99, 0, 0, 0, 0, 0);
    bus.count_down = 1'b0;
    check("mode_switch_hold", 0, 59, 59, 99, 0, 0, 0, 0, 0);
    run_cycles(10);
    check("carry_chain", 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lap on the tick edge captures the pre-tick value.
    do_load(0, 0, 0, 9);
    bus.run = 1'b1;
    repeat (9) step();
    bus.lap = 1'b1;
    step();
    bus.lap = 1'b0;
    bus.run = 1'b0;
    exp_lap(0, 0, 0, 9);
    check("lap_on_tick", 0, 0, 0, 10, 0, 0, 0, 1, 0);
    lap_pulse(); exp_lap(0, 0, 0, 10);
    run_cycles(10);
    lap_pulse(); exp_lap(0, 0, 0, 11);
    run_cycles(10);
    lap_pulse(); exp_lap(0, 0, 0, 12);
    run_cycles(10);
    lap_pulse();
    check("lap_full_drop", 0, 0, 0, 13, 0, 0, 1, 4, 0);
    repeat (4) rd_pulse();
    check("laps_drained", 0, 0, 0, 13, 0, 0, 1, 0, 0);
    rd_pulse();
    check("rd_while_empty", 0, 0, 0, 13, 0, 0, 1, 0, 0);

    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    check("clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Simultaneous lap and lap_rd on a full buffer.
    do_load(0, 0, 0, 50);
    lap_pulse(); exp_lap(0, 0, 0, 50);
    run_cycles(10);
    lap_pulse(); exp_lap(0, 0, 0, 51);
    run_cycles(10);
    lap_pulse(); exp_lap(0, 0, 0, 52);
    run_cycles(10);
    lap_pulse(); exp_lap(0, 0, 0, 53);
    bus.lap    = 1'b1;
    bus.lap_rd = 1'b1;
    step();
    bus.lap    = 1'b0;
    bus.lap_rd = 1'b0;
    exp_lap(0, 0, 0, 53);
    check("push_pop_full", 0, 0, 0, 53, 0, 0, 0, 4, 0);
    repeat (4) rd_pulse();

    // Async reset mid-count with two laps buffered.
    lap_pulse();
    lap_pulse();
    check("two_laps", 0, 0, 0, 53, 0, 0, 0, 2, 0);
    bus.run = 1'b1;
    repeat (5) step();
    reset_n = 1'b0;
    check("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1);
    bus.run = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    run_cycles(9);
    check("post_reset_div_9", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_cycles(1);
    check("post_reset_tick", 0, 0, 0, 1, 0, 0, 0, 0, 0);

    fin_req = 1'b1;
    step();
    fin_req = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 Parameter CLOCK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 100, count resolution in Hz; CLOCK_HZ/TICK_HZ (DIV) SHALL be an integer >= 2.
REQ-003 Parameter LAP_DEPTH, default 4, lap buffer entries; power of 2, range 2..16.
REQ-004 clock  in  1  single system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 run  in  1  1 = counting enabled; 0 = hold the count and the divider.
REQ-007 clear  in  1  synchronous clear of count, divider and sticky flags.
REQ-008 count_down  in  1  0 = count up, 1 = count down.
REQ-009 load  in  1  synchronous load of load_epoch/load_m into the count.
REQ-010 load_epoch  in  18  {hour[5:0], minute[5:0], second[5:0]} load value.
REQ-011 load_m  in  7  centisecond load value, 0..99.
REQ-012 lap  in  1  one-cycle request to capture the current time.
REQ-013 lap_rd  in  1  one-cycle pop of the lap buffer head.
REQ-014 epoch  out  18  {hour, minute, second} current count.
REQ-015 m_epoch  out  8  current sub-second count, zero-extended.
REQ-016 lap_epoch  out  25  {hour, minute, second, m[6:0]} at buffer head.
REQ-017 lap_valid  out  1  buffer non-empty.
REQ-018 lap_count  out  5  entries held, 0..LAP_DEPTH.
REQ-019 lap_lost  out  1  sticky: a lap was dropped because the buffer was full.
REQ-020 expired  out  1  sticky: a down-count reached zero.
REQ-021 overflow  out  1  sticky: an up-count wrapped past 23:59:59.99.

Function
REQ-022 Divider SHALL count 0..DIV-1 while run=1; tick is asserted for the single cycle in which divider==DIV-1, and the divider then returns to 0.
REQ-023 Count SHALL update only on tick cycles; no derived or gated clocks.
REQ-024 Field ranges SHALL be m 0..99, second 0..59, minute 0..59, hour 0..23, with carry or borrow in the same tick.
REQ-025 Up mode: 23:59:59.99 plus tick SHALL give 00:00:00.00 and set overflow; counting continues.
REQ-026 Down mode: 00:00:00.01 minus tick SHALL give 00:00:00.00 and set expired; while the count is zero in down mode, ticks SHALL leave it unchanged.
REQ-027 Priority SHALL be clear > load > tick; load SHALL clear expired and overflow and reset the divider.
REQ-028 A load field out of range (m>99, s>59, min>59, h>23) SHALL saturate to that field's maximum.
REQ-029 lap SHALL push the pre-update count of that cycle, including when lap coincides with a tick.
REQ-030 Lap buffer SHALL be first-word-fall-through: lap_epoch is valid whenever lap_valid=1.
REQ-031 lap_rd while empty SHALL be ignored.
REQ-032 lap while full and without lap_rd SHALL drop the entry and set lap_lost.
REQ-033 lap and lap_rd in the same cycle while full SHALL pop and push, leaving lap_count unchanged.
REQ-034 clear SHALL empty the lap buffer and clear lap_lost.
REQ-035 Changing count_down mid-count SHALL take effect on the next tick without altering the count.

Reset
REQ-036 reset_n=0 SHALL asynchronously zero the divider, count, lap buffer pointers and all outputs, including every sticky flag.
REQ-037 Reset asserted mid-count or mid-lap SHALL discard all state; the first tick after release SHALL occur DIV cycles after run is high.

Configuration
REQ-038 Macro LAP_TIMER_LAP_BUFFER_EN defined: lap buffer per REQ-029..REQ-034.
REQ-039 Macro LAP_TIMER_LAP_BUFFER_EN undefined: no buffer storage; lap and lap_rd ignored; lap_epoch, lap_valid, lap_count and lap_lost tied to 0.

Verification
REQ-040 CLOCK_HZ=100, TICK_HZ=10, run=1 for 1000 cycles from reset -> m_epoch=100 is never seen; epoch=0 and m_epoch=... (100 ticks) gives second=1, m=0.
REQ-041 Load 23:59:59.99, up mode, one tick -> epoch=0, m_epoch=0, overflow=1.
REQ-042 Load 00:00:00.02, down mode, 3 ticks -> count holds at 0 from the 2nd tick, expired=1.
REQ-043 LAP_DEPTH=4, 5 laps without lap_rd -> lap_count=4, lap_lost=1; 4 lap_rd return the first 4 captures in order.
REQ-044 lap on the tick edge taking 00:00:00.09 to 00:00:00.10 -> captured lap_epoch m=9.
REQ-045 Assert reset_n=0 mid-count with 2 laps buffered -> all outputs 0 in the same cycle; macro undefined build -> lap outputs constant 0.
